data_memory_param: RTL and testbench

- Parametrised single-port synchronous data memory. Successor to the fixed 256x16 data memory.
- Adds configurable width and depth, selectable read-during-write mode, and a read-valid strobe.
- Adds a hardware clear sequencer that zero-fills the array after reset or on request.
- Sits between the control FSM and the ALU datapath: the FSM drives address and write enable, the ALU A-operand is write data, and q feeds the register-file write mux.

---
 rtl/data_memory_param.sv | 100 ++++++++++
 tb/tb_data_memory_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/data_memory_param.sv
// Purpose: parametrised single-port data memory with zero-fill sweep; DATA_MEMORY_PARITY_EN adds per-word even parity and par_err.
// Latency: 1 cycle from an accepted rden to q/q_valid; a clear sweep takes 2**ADDR_W cycles.
// Backpressure: none; while busy is high every wren/rden/clr is dropped.
module data_memory_param #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int READ_MODE = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    input  logic              rden,
    input  logic              clr,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
`ifdef DATA_MEMORY_PARITY_EN
    output logic              par_err,
`endif
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              rd_acc, wr_acc, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdat, rd_word;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        case (state)
            ST_CLEAR: begin
                ptr_nxt = ptr + ADDR_W'(1);
                if (ptr == {ADDR_W{1'b1}}) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                ptr_nxt = '0;
                // clr wins over any same-cycle access
                if (clr) begin
                    state_nxt = ST_CLEAR;
                end else begin
                    rd_acc = rden;
                    wr_acc = wren;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign busy     = (state == ST_CLEAR);
    assign mem_we   = !Reset && (busy || wr_acc);
    assign mem_addr = busy ? ptr : address;
    assign mem_wdat = busy ? '0 : data;
    assign rd_word  = (READ_MODE != 0 && wr_acc) ? data : mem[address];

    always_ff @(posedge Clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdat;
    end

`ifdef DATA_MEMORY_PARITY_EN
    logic [DEPTH-1:0] par_mem;
    logic             rd_par;

    // parity of all-zero data is 0, so the sweep needs no special case
    assign rd_par = (READ_MODE != 0 && wr_acc) ? ^data : par_mem[address];

    always_ff @(posedge Clock) begin
        if (mem_we) par_mem[mem_addr] <= ^mem_wdat;
    end

    always_ff @(posedge Clock) begin
        if (Reset) par_err <= 1'b0;
        else       par_err <= rd_acc && (rd_par != ^rd_word);
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= ST_CLEAR;
            ptr     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            q_valid <= rd_acc;
            if (rd_acc) q <= rd_word;
        end
    end

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param: read-old and write-through instances share stimulus; table vectors plus sweep/reset sequences.
module tb_data_memory_param;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [7:0]  address;
    logic [15:0] data;
    logic        wren, rden, clr;
    logic [15:0] q0, q1;
    logic        qv0, qv1, busy0, busy1;
`ifdef DATA_MEMORY_PARITY_EN
    logic        pe0, pe1;
`endif

    always #5 Clock = ~Clock;

    data_memory_param #(.DATA_W(16), .ADDR_W(8), .READ_MODE(0)) dut (
        .Clock(Clock), .Reset(Reset), .address(address), .data(data),
        .wren(wren), .rden(rden), .clr(clr), .q(q0), .q_valid(qv0),
`ifdef DATA_MEMORY_PARITY_EN
        .par_err(pe0),
`endif
        .busy(busy0));

    data_memory_param #(.DATA_W(16), .ADDR_W(8), .READ_MODE(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .address(address), .data(data),
        .wren(wren), .rden(rden), .clr(clr), .q(q1), .q_valid(qv1),
`ifdef DATA_MEMORY_PARITY_EN
        .par_err(pe1),
`endif
        .busy(busy1));

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] dat;
        logic        we, re;
        logic [15:0] eq0, eq1;
        logic        ev;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] q0, q1;
        logic        v, b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // drive one cycle at negedge, compare the post-edge outputs at the next negedge
    task automatic cycle(input int id, input logic rst, input logic c, input logic we, input logic re,
                         input logic [7:0] a, input logic [15:0] d,
                         input logic [15:0] eq0, input logic [15:0] eq1, input logic ev, input logic eb);
        exp_t e;
        Reset = rst; clr = c; wren = we; rden = re; address = a; data = d;
        e.id = id; e.q0 = eq0; e.q1 = eq1; e.v = ev; e.b = eb;
        sb.push_back(e);
        @(posedge Clock);
        @(negedge Clock);
        e = sb.pop_front();
        chk($sformatf("v%0d_q_rm0", e.id), {16'h0, q0}, {16'h0, e.q0});
        chk($sformatf("v%0d_q_rm1", e.id), {16'h0, q1}, {16'h0, e.q1});
        chk($sformatf("v%0d_q_valid", e.id), {30'h0, qv1, qv0}, {30'h0, e.v, e.v});
        chk($sformatf("v%0d_busy", e.id), {30'h0, busy1, busy0}, {30'h0, e.b, e.b});
        Reset = 1'b0; clr = 1'b0; wren = 1'b0; rden = 1'b0;
    endtask

    // called right after a cycle that left busy high; counts busy windows including that one
    task automatic busy_run(input int clr_at, input logic [15:0] hold, output int n, output int noisy);
        n = 1;
        noisy = 0;
        Reset = 1'b0; rden = 1'b1; wren = 1'b1; address = 8'd6; data = 16'hDEAD;
        for (int k = 0; k < 400; k++) begin
            clr = (n == clr_at);
            @(posedge Clock);
            @(negedge Clock);
            if (!busy0) break;
            n++;
            if (qv0 || qv1 || q0 !== hold || q1 !== hold || busy1 !== busy0) noisy++;
        end
        clr = 1'b0; rden = 1'b0; wren = 1'b0;
    endtask

    vec_t vecs[14];
    int   n, noisy;

    initial begin
        vecs[0]  = '{8'd0,   16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[1]  = '{8'd6,   16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[2]  = '{8'd255, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[3]  = '{8'd0,   16'h002A, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{8'd6,   16'h0001, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[5]  = '{8'd0,   16'h0000, 1'b0, 1'b1, 16'h002A, 16'h002A, 1'b1};
        vecs[6]  = '{8'd6,   16'h0000, 1'b0, 1'b1, 16'h0001, 16'h0001, 1'b1};
        vecs[7]  = '{8'd1,   16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[8]  = '{8'd11,  16'h1234, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[9]  = '{8'd11,  16'hBEEF, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b1};
        vecs[10] = '{8'd11,  16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF, 1'b1};
        vecs[11] = '{8'd11,  16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF, 1'b1};
        vecs[12] = '{8'd11,  16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[13] = '{8'd6,   16'h0055, 1'b1, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0};

        Reset = 1'b1; clr = 1'b0; wren = 1'b0; rden = 1'b0; address = '0; data = '0;

        // reset, then initial sweep of 256 cycles
        cycle(100, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        busy_run(-1, 16'h0000, n, noisy);
        chk("init_busy_cycles", n, 256);
        chk("init_sweep_quiet", noisy, 0);

        for (int i = 0; i < 14; i++)
            cycle(i, 1'b0, 1'b0, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].dat,
                  vecs[i].eq0, vecs[i].eq1, vecs[i].ev, 1'b0);

        // clr beats a same-cycle write; sweep ignores accesses and keeps q
        cycle(101, 1'b0, 1'b1, 1'b1, 1'b0, 8'd7, 16'h0077, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1);
        busy_run(-1, 16'hBEEF, n, noisy);
        chk("clr_busy_cycles", n, 256);
        chk("clr_sweep_quiet", noisy, 0);
        cycle(102, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6, 16'h0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        cycle(103, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 16'h0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // reset during a read drops the result
        cycle(104, 1'b0, 1'b0, 1'b1, 1'b0, 8'd9, 16'h9999, 16'h0000, 16'h0000, 1'b0, 1'b0);
        cycle(105, 1'b1, 1'b0, 1'b0, 1'b1, 8'd9, 16'h0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // reset at sweep cycle 100 restarts; clr at cycle 50 of the new sweep is ignored
        for (int k = 0; k < 99; k++) begin
            @(posedge Clock);
            @(negedge Clock);
        end
        chk("sweep100_busy", {31'h0, busy0}, 32'd1);
        cycle(106, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        busy_run(50, 16'h0000, n, noisy);
        chk("restart_busy_cycles", n, 256);
        chk("restart_sweep_quiet", noisy, 0);
        cycle(107, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 16'h0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        cycle(108, 1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 16'h0, 16'h0000, 16'h0000, 1'b1, 1'b0);

`ifdef DATA_MEMORY_PARITY_EN
        begin
            logic p;
            cycle(110, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 16'h00FF, 16'h0000, 16'h0000, 1'b0, 1'b0);
            cycle(111, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 16'h0101, 16'h0000, 16'h0000, 1'b0, 1'b0);
            p = dut.par_mem[3];
            force dut.par_mem[3] = ~p;
            cycle(112, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 16'h0, 16'h00FF, 16'h00FF, 1'b1, 1'b0);
            chk("par_err_forced", {31'h0, pe0}, 32'd1);
            chk("par_err_clean_rm1", {31'h0, pe1}, 32'd0);
            release dut.par_mem[3];
            cycle(113, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 16'h0, 16'h0101, 16'h0101, 1'b1, 1'b0);
            chk("par_err_addr4", {31'h0, pe0}, 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
